// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with 3-point
// majority sampling, delivering each good byte with a one-cycle valid pulse.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [5:0]            r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [2:0]            r_samp;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_fail;

    logic                  w_rx_s;
    logic [5:0]            w_half;
    logic                  w_last;
    logic                  w_maj;

    assign w_rx_s = r_sync2;
    assign w_half = r_prescale >> 1;
    assign w_last = (r_edge_cnt == r_prescale - 6'd1);
    assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[1] & r_samp[2]) | (r_samp[0] & r_samp[2]);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking so r_sync2 takes r_sync1's value from before this edge.
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_prescale <= 6'd0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= '0;
            r_samp     <= 3'b111;
            r_shift    <= '0;
            r_par_fail <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            if (r_state != IDLE) begin
                r_edge_cnt <= w_last ? 6'd0 : r_edge_cnt + 6'd1;
                if (r_edge_cnt == w_half - 6'd1) r_samp[0] <= w_rx_s;
                if (r_edge_cnt == w_half)        r_samp[1] <= w_rx_s;
                if (r_edge_cnt == w_half + 6'd1) r_samp[2] <= w_rx_s;
            end

            case (r_state)
                IDLE: begin
                    r_edge_cnt <= 6'd0;
                    r_bit_cnt  <= '0;
                    if (!w_rx_s) begin
                        r_state    <= START;
                        r_prescale <= Prescale;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_fail <= 1'b0;
                        par_err    <= 1'b0;
                        stp_err    <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that votes high was a glitch.
                    if (w_last) r_state <= w_maj ? IDLE : DATA;
                end
                DATA: begin
                    if (w_last) begin
                        r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_last) begin
                        if (w_maj != ((^r_shift) ^ r_par_typ)) r_par_fail <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_last) begin
                        if (w_maj && !r_par_fail) begin
                            data_valid <= 1'b1;
                            P_DATA     <= r_shift;
                        end else begin
                            par_err <= r_par_fail;
                            stp_err <= ~w_maj;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive side of the UART link: recovers asynchronous serial frames (start, 8 data bits LSB first, optional parity, one stop bit) from an oversampled line and delivers the parallel byte with a one-cycle valid pulse. Pairs with the existing UART transmitter and shares its frame format: idle-high line, `PAR_EN`/`PAR_TYP` configuration. Contains its own synchronizer, oversampling edge counter, bit counter, majority-vote sampler, deserializer, parity and stop checkers, and control FSM.

## Interface

- `DATA_WIDTH`, 8, data bits per frame.
- `CLK`  in  1  oversampling clock, `Prescale` cycles per bit.
- `RST`  in  1  reset, synchronous, active-low.
- `RX_IN`  in  1  asynchronous serial line, idle high.
- `Prescale`  in  6  cycles per bit. Legal values: 8, 16, 32. Captured at frame start.
- `PAR_EN`  in  1  1 = parity bit present. Captured at frame start.
- `PAR_TYP`  in  1  0 = even, 1 = odd. Captured at frame start.
- `P_DATA`  out  DATA_WIDTH  last good byte. Reset 0.
- `data_valid`  out  1  one-cycle pulse on a good frame. Reset 0.
- `par_err`  out  1  parity error of the last frame. Reset 0.
- `stp_err`  out  1  stop error of the last frame. Reset 0.

## Operation

- **Synchronizer:** `RX_IN` passes through two flops, both reset to 1; all logic uses the synchronized `rx_s`.
- **Edge counter:**
  - Runs 0..P-1 inside each bit, where P is the captured `Prescale`.
  - Wraps to 0 and increments the bit counter at P-1.
  - Held at 0 in IDLE.
- **Sampler:**
  - Samples `rx_s` at edge counts P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, valid from edge count P/2+2.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `rx_s`=0, next state START. At that transition, capture `Prescale`/`PAR_EN`/`PAR_TYP` and clear `par_err`/`stp_err`.
  - START: at edge P-1, a sampled 0 goes to DATA. A sampled 1 is a glitch and goes to IDLE with no flags and no pulse.
  - DATA: shift the sampled bit in LSB first. After bit DATA_WIDTH-1 ends, go to PARITY if `PAR_EN`, else STOP.
  - PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. A mismatch latches an internal parity-fail flag. At edge P-1, go to STOP.
  - STOP: at edge P-1, evaluate the frame and go to IDLE.
    - A sampled stop of 1 with no parity fail gives `data_valid`=1 and `P_DATA`=shifted byte.
    - Otherwise `data_valid` stays 0, `P_DATA` is unchanged, and `par_err`/`stp_err` are set per cause. Both may be set together.
- **Error flags:** `par_err`/`stp_err` hold until the next START entry or reset.
- **Frame length:** N×P cycles, where N = 10 (no parity) or 11 (parity).
- **Back-to-back frames:** a start edge seen during the stop bit is ignored. Detection resumes in IDLE.
- **Reset mid-frame:** `RST`=0 at a clock edge returns to IDLE and clears all outputs, counters, shift register and synchronizer (to 1) on that edge.
- **Prescale change mid-frame:** has no effect until the next frame.

## Timing

- Let c be the first `CLK` edge at which `RX_IN` is sampled low. `rx_s` is low after edge c+1, and START is the state from edge c+2 (T0).
- The stop bit's last cycle is T0+N×P-1. `data_valid`, `P_DATA`, `par_err` and `stp_err` update at edge T0+N×P.
- `data_valid` is high for exactly 1 cycle.
- IDLE is re-entered on the same edge as the output update. A new start can be detected from the next cycle.
- A glitch shorter than P/2-1 cycles is rejected: IDLE is re-entered at T0+P.
- The design tolerates ±1 cycle of line skew per bit at P=8 through majority sampling.

## Test plan

- **P=8, PAR_EN=0, byte 0xA5:** `data_valid` pulses 1 cycle at T0+80 with `P_DATA`=0xA5, and `par_err`=`stp_err`=0.
- **P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0:** valid at T0+176 with `P_DATA`=0x3C. Sending parity bit 1 instead gives no pulse, `par_err`=1, and `P_DATA` keeps its old value.
- **P=32, PAR_EN=1, PAR_TYP=1, byte 0xFF, parity 1, stop bit driven 0:** no pulse, `stp_err`=1, `par_err`=0, both hold until the next start.
- **P=8, RX_IN low for 2 cycles then high:** return to IDLE at T0+8 with no `data_valid` and no flags. A following valid 0x55 frame is received correctly.
- **Two back-to-back 0x01 then 0x80 frames at P=16, and a single-cycle glitch on data bit 3 at sample point P/2:** both bytes are received exactly. The glitch is outvoted.
- **RST=0 for 1 cycle mid-data of a frame:** all outputs are 0 after that edge. The next complete frame 0x5A is received correctly.
